// File: rtl/lc3b_types.sv
// Shared types for the branch target buffer.
// Holds the 2-bit saturating direction counter type, its allocation value,
// the BTB controller state type and a counter update helper.
package lc3b_types;

   typedef logic [1:0] ctr_t;

   // Weakly taken: a freshly allocated branch predicts taken.
   localparam ctr_t CTR_INIT = 2'b10;

   typedef enum logic {
      READY = 1'b0,
      FLUSH = 1'b1
   } btb_state_e;

   // Saturating increment on taken, saturating decrement on not-taken.
   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t r;
      if (taken) begin
         r = (c == 2'b11) ? c : c + 2'd1;
      end else begin
         r = (c == 2'b00) ? c : c - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU helper for one set.
// Node 0 is the root; node n has children 2n+1 (lower half) and 2n+2 (upper
// half). A node bit of 1 points the victim search at the upper half.
// Ports:
//   bits_cur  - current PLRU bits of the set
//   touch_way - way being touched (hit or allocated)
//   victim    - way the current bits point at
//   bits_next - bits after touching touch_way (path points away from it)
module btb_plru #(
   parameter int unsigned WAYS = 4,
   localparam int unsigned LW = $clog2(WAYS)
) (
   input  logic [WAYS-2:0] bits_cur,
   input  logic [LW-1:0]   touch_way,
   output logic [LW-1:0]   victim,
   output logic [WAYS-2:0] bits_next
);

   always_comb begin
      logic [LW-1:0] node;
      victim = '0;
      node   = '0;
      for (int l = 0; l < int'(LW); l++) begin
         victim = LW'({victim, bits_cur[node]});
         node   = LW'((32'(node) << 1) + 32'd1 + 32'(bits_cur[node]));
      end
   end

   always_comb begin
      logic [LW-1:0] node;
      logic [LW-1:0] w;
      logic          dir;
      bits_next = bits_cur;
      node      = '0;
      w         = touch_way;
      for (int l = 0; l < int'(LW); l++) begin
         dir             = w[LW-1];
         bits_next[node] = ~dir;
         node            = LW'((32'(node) << 1) + 32'd1 + 32'(dir));
         w               = w << 1;
      end
   end

endmodule

// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer with tree-PLRU replacement.
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   lookup_valid, lookup_pc   - lookup request; answered on pred_* next cycle
//   pred_valid/hit/taken/target - registered lookup response
//   upd_valid/ready/pc/taken/target - resolved-branch update handshake
//   flush, busy               - flush request pulse, flush walk in progress
module btb_nway
   import lc3b_types::*;
#(
   parameter int unsigned WAYS = 4,
   parameter int unsigned SETS = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lookup_valid,
   input  logic [15:0] lookup_pc,
   output logic        pred_valid,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [15:0] pred_target,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [15:0] upd_pc,
   input  logic        upd_taken,
   input  logic [15:0] upd_target,
   input  logic        flush,
   output logic        busy
);

   localparam int unsigned IDX = $clog2(SETS);
   localparam int unsigned TW  = 15 - IDX;
   localparam int unsigned LW  = $clog2(WAYS);

   btb_state_e     state_q, state_d;
   logic [IDX-1:0] flush_cnt_q, flush_cnt_d;

   logic [WAYS-1:0] valid_q [SETS];
   logic [WAYS-2:0] plru_q  [SETS];
   ctr_t            ctr_q   [SETS][WAYS];
   logic [TW-1:0]   tag_q   [SETS][WAYS];
   logic [15:0]     tgt_q   [SETS][WAYS];

   logic ready;
   assign ready     = (state_q == READY);
   assign busy      = (state_q == FLUSH);
   // A flush request pre-empts a same-cycle update.
   assign upd_ready = ready & ~flush;

   // Bit 0 of a PC never selects anything.
   logic unused_pc_lsb;
   assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

   // Lookup side
   logic [IDX-1:0]  lk_idx;
   logic [TW-1:0]   lk_tag;
   logic            lk_hit;
   logic [LW-1:0]   lk_way;
   logic [WAYS-2:0] lk_plru_next;
   logic [LW-1:0]   lk_victim_unused;

   assign lk_idx = lookup_pc[IDX:1];
   assign lk_tag = lookup_pc[15:IDX+1];

   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
            lk_hit = 1'b1;
            lk_way = LW'(w);
         end
      end
   end

   btb_plru #(.WAYS(WAYS)) u_plru_lk (
      .bits_cur  (plru_q[lk_idx]),
      .touch_way (lk_way),
      .victim    (lk_victim_unused),
      .bits_next (lk_plru_next)
   );

   // Update side
   logic [IDX-1:0]  u_idx;
   logic [TW-1:0]   u_tag;
   logic            u_hit;
   logic [LW-1:0]   u_hit_way;
   logic            u_free;
   logic [LW-1:0]   u_free_way;
   logic [LW-1:0]   u_victim;
   logic [LW-1:0]   u_way;
   logic [WAYS-2:0] u_plru_next;
   logic            u_write;

   assign u_idx = upd_pc[IDX:1];
   assign u_tag = upd_pc[15:IDX+1];

   always_comb begin
      u_hit     = 1'b0;
      u_hit_way = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
            u_hit     = 1'b1;
            u_hit_way = LW'(w);
         end
      end
   end

   // Descending scan so the lowest-numbered invalid way is the one kept.
   always_comb begin
      u_free     = 1'b0;
      u_free_way = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[u_idx][w]) begin
            u_free     = 1'b1;
            u_free_way = LW'(w);
         end
      end
   end

   always_comb begin
      u_way   = u_hit ? u_hit_way : (u_free ? u_free_way : u_victim);
      // Hits always train; misses allocate only when taken.
      u_write = upd_valid & upd_ready & (u_hit | upd_taken);
   end

   btb_plru #(.WAYS(WAYS)) u_plru_upd (
      .bits_cur  (plru_q[u_idx]),
      .touch_way (u_way),
      .victim    (u_victim),
      .bits_next (u_plru_next)
   );

   // Controller
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         READY: begin
            if (flush) begin
               state_d     = FLUSH;
               flush_cnt_d = '0;
            end
         end
         FLUSH: begin
            if (flush_cnt_q == IDX'(SETS - 1)) begin
               state_d     = READY;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = READY;
            flush_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= READY;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Valid, PLRU and counter state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < int'(SETS); s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
            for (int w = 0; w < int'(WAYS); w++) begin
               ctr_q[s][w] <= '0;
            end
         end
      end else if (busy) begin
         valid_q[flush_cnt_q] <= '0;
         plru_q[flush_cnt_q]  <= '0;
      end else begin
         if (lookup_valid && lk_hit) begin
            plru_q[lk_idx] <= lk_plru_next;
         end
         // Later assignment: the update's touch wins on a same-set collision.
         if (u_write) begin
            plru_q[u_idx]         <= u_plru_next;
            valid_q[u_idx][u_way] <= 1'b1;
            ctr_q[u_idx][u_way]   <= u_hit ? ctr_next(ctr_q[u_idx][u_way], upd_taken)
                                           : CTR_INIT;
         end
      end
   end

   // Tag and target storage, not reset
   always_ff @(posedge clk) begin
      if (u_write && upd_taken) begin
         tag_q[u_idx][u_way] <= u_tag;
         tgt_q[u_idx][u_way] <= upd_target;
      end
   end

   // Registered lookup response; during the flush walk lookups report a miss.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pred_valid  <= 1'b0;
         pred_hit    <= 1'b0;
         pred_taken  <= 1'b0;
         pred_target <= '0;
      end else begin
         pred_valid  <= lookup_valid;
         pred_hit    <= lookup_valid & ready & lk_hit;
         pred_taken  <= lookup_valid & ready & lk_hit & ctr_q[lk_idx][lk_way][1];
         pred_target <= (lookup_valid & ready & lk_hit) ? tgt_q[lk_idx][lk_way] : '0;
      end
   end

endmodule

// File: tb/tb_btb_nway.sv
// Self-checking bench for btb_nway (WAYS=4, SETS=8): directed scenarios and
// randomized traffic compared against a behavioural BTB model.
module tb_btb_nway;

   localparam int WAYS = 4;
   localparam int SETS = 8;
   localparam int IDX  = 3;
   localparam int LOG  = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        lookup_valid;
   logic [15:0] lookup_pc;
   logic        pred_valid;
   logic        pred_hit;
   logic        pred_taken;
   logic [15:0] pred_target;
   logic        upd_valid;
   logic        upd_ready;
   logic [15:0] upd_pc;
   logic        upd_taken;
   logic [15:0] upd_target;
   logic        flush;
   logic        busy;

   always #5 clk = ~clk;

   btb_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .lookup_valid (lookup_valid),
      .lookup_pc    (lookup_pc),
      .pred_valid   (pred_valid),
      .pred_hit     (pred_hit),
      .pred_taken   (pred_taken),
      .pred_target  (pred_target),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_target   (upd_target),
      .flush        (flush),
      .busy         (busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_valid [SETS][WAYS];
   int m_tag   [SETS][WAYS];
   int m_tgt   [SETS][WAYS];
   int m_ctr   [SETS][WAYS];
   // m_node[s][level][k]: 1 = victim search goes to the upper half of that subtree
   bit m_node  [SETS][LOG][WAYS/2];
   bit m_busy;
   int m_cnt;

   function automatic int set_of(input int pc);
      return (pc >> 1) % SETS;
   endfunction

   function automatic int tag_of(input int pc);
      return pc >> (IDX + 1);
   endfunction

   function automatic int find(input int s, input int t);
      for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   function automatic int victim(input int s);
      int k = 0;
      for (int l = 0; l < LOG; l++) k = 2 * k + int'(m_node[s][l][k]);
      return k;
   endfunction

   task automatic touch(input int s, input int w);
      for (int l = 0; l < LOG; l++) begin
         int k = w >> (LOG - l);
         int d = (w >> (LOG - 1 - l)) & 1;
         m_node[s][l][k] = (d == 0);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0;
            m_ctr[s][w]   = 0;
         end
         for (int l = 0; l < LOG; l++) for (int k = 0; k < WAYS / 2; k++) m_node[s][l][k] = 0;
      end
      m_busy = 0;
      m_cnt  = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int ls, lw, us, uw;
      bit u_touch;
      if (m_busy) begin
         for (int w = 0; w < WAYS; w++) m_valid[m_cnt][w] = 0;
         for (int l = 0; l < LOG; l++) for (int k = 0; k < WAYS / 2; k++) m_node[m_cnt][l][k] = 0;
         m_cnt++;
         if (m_cnt == SETS) m_busy = 0;
         return;
      end
      ls = set_of(int'(lookup_pc));
      lw = lookup_valid ? find(ls, tag_of(int'(lookup_pc))) : -1;
      us = set_of(int'(upd_pc));
      u_touch = 0;
      if (upd_valid && !flush) begin
         uw = find(us, tag_of(int'(upd_pc)));
         if (uw >= 0) begin
            if (upd_taken) begin
               if (m_ctr[us][uw] < 3) m_ctr[us][uw]++;
               m_tgt[us][uw] = int'(upd_target);
            end else if (m_ctr[us][uw] > 0) begin
               m_ctr[us][uw]--;
            end
            touch(us, uw);
            u_touch = 1;
         end else if (upd_taken) begin
            uw = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[us][w]) uw = w;
            if (uw < 0) uw = victim(us);
            m_valid[us][uw] = 1;
            m_tag[us][uw]   = tag_of(int'(upd_pc));
            m_tgt[us][uw]   = int'(upd_target);
            m_ctr[us][uw]   = 2;
            touch(us, uw);
            u_touch = 1;
         end
      end
      if (lw >= 0 && !(u_touch && us == ls)) touch(ls, lw);
      if (flush) begin
         m_busy = 1;
         m_cnt  = 0;
      end
   endtask

   // One clock: check combinational outputs, predict the response, clock, compare.
   task automatic cycle();
      bit e_pv, e_hit, e_tk;
      int e_tgt, w, s;
      #1;
      check("upd_ready", 32'(upd_ready), 32'(!m_busy && !flush));
      check("busy", 32'(busy), 32'(m_busy));
      e_pv  = lookup_valid;
      e_hit = 0;
      e_tk  = 0;
      e_tgt = 0;
      if (lookup_valid && !m_busy) begin
         s = set_of(int'(lookup_pc));
         w = find(s, tag_of(int'(lookup_pc)));
         if (w >= 0) begin
            e_hit = 1;
            e_tk  = (m_ctr[s][w] >= 2);
            e_tgt = m_tgt[s][w];
         end
      end
      @(posedge clk);
      model_step();
      #1;
      check("pred_valid", 32'(pred_valid), 32'(e_pv));
      if (e_pv) begin
         check("pred_hit", 32'(pred_hit), 32'(e_hit));
         check("pred_taken", 32'(pred_taken), 32'(e_tk));
         check("pred_target", 32'(pred_target), 32'(e_tgt));
      end
   endtask

   task automatic drive(input bit lv, input logic [15:0] lpc, input bit uv,
                        input logic [15:0] upc, input bit ut, input logic [15:0] utgt,
                        input bit fl);
      lookup_valid = lv;
      lookup_pc    = lpc;
      upd_valid    = uv;
      upd_pc       = upc;
      upd_taken    = ut;
      upd_target   = utgt;
      flush        = fl;
      cycle();
   endtask

   task automatic lookup(input logic [15:0] pc);
      drive(1, pc, 0, 16'h0, 0, 16'h0, 0);
   endtask

   task automatic update(input logic [15:0] pc, input bit t, input logic [15:0] tgt);
      drive(0, 16'h0, 1, pc, t, tgt, 0);
   endtask

   task automatic idle();
      drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
   endtask

   task automatic do_reset();
      lookup_valid = 0;
      lookup_pc    = '0;
      upd_valid    = 0;
      upd_pc       = '0;
      upd_taken    = 0;
      upd_target   = '0;
      flush        = 0;
      reset_n      = 0;
      model_reset();
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pred_valid", 32'(pred_valid), 32'd0);
      check("rst_upd_ready", 32'(upd_ready), 32'd1);
      @(negedge clk);
      reset_n = 1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_pc();
      int t = 32'h200 + int'($urandom_range(0, 5));
      int i = int'($urandom_range(0, SETS - 1));
      return 16'((t << (IDX + 1)) | (i << 1) | int'($urandom_range(0, 1)));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nbusy;
      reset_n = 1;
      do_reset();

      // Empty BTB misses.
      lookup(16'h1002);
      check("first_lk_valid", 32'(pred_valid), 32'd1);
      check("first_lk_hit", 32'(pred_hit), 32'd0);
      check("first_lk_target", 32'(pred_target), 32'd0);

      // Allocation on a taken update.
      update(16'h1002, 1, 16'h2000);
      lookup(16'h1002);
      check("alloc_hit", 32'(pred_hit), 32'd1);
      check("alloc_taken", 32'(pred_taken), 32'd1);
      check("alloc_target", 32'(pred_target), 32'h2000);

      // Counter training and saturation at 00.
      update(16'h1002, 0, 16'h0);
      update(16'h1002, 0, 16'h0);
      lookup(16'h1002);
      check("ctr00_hit", 32'(pred_hit), 32'd1);
      check("ctr00_taken", 32'(pred_taken), 32'd0);
      update(16'h1002, 0, 16'h0);
      update(16'h1002, 1, 16'h3000);
      lookup(16'h1002);
      check("ctr01_taken", 32'(pred_taken), 32'd0);
      check("ctr01_target", 32'(pred_target), 32'h3000);

      // Fill index 1 and force a PLRU eviction: way 0 (tag 0x100) is the victim.
      for (int t = 'h100; t <= 'h104; t++) update(16'((t << 4) | 2), 1, 16'(16'h4000 + t));
      lookup(16'h1042);
      check("evict_last_hit", 32'(pred_hit), 32'd1);
      check("evict_last_target", 32'(pred_target), 32'h4104);
      lookup(16'h1032);
      check("evict_keep_hit", 32'(pred_hit), 32'd1);
      lookup(16'h1002);
      check("evict_victim_miss", 32'(pred_hit), 32'd0);

      // Flush with a colliding update: update dropped, walk takes SETS cycles.
      drive(1, 16'h1042, 1, 16'h5002, 1, 16'h5555, 1);
      nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) nbusy++;
         drive(1, 16'h1042, 1, 16'h1052, 1, 16'h1111, 0);
      end
      check("flush_len", 32'(nbusy), 32'(SETS));
      lookup(16'h1042);
      check("flush_miss_a", 32'(pred_hit), 32'd0);
      lookup(16'h5002);
      check("flush_drop_upd", 32'(pred_hit), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 700; i++) begin
         drive($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 1) == 1, rand_pc(),
               $urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 49) == 0);
      end

      // Reset in the middle of a flush walk.
      for (int i = 0; i < 2 * SETS && m_busy; i++) idle();
      for (int i = 0; i < 16; i++) update(rand_pc(), 1, 16'($urandom));
      drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
      for (int i = 0; i < 3; i++) idle();
      check("midflush_busy_before", 32'(busy), 32'd1);
      #2;
      do_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int t = 'h200; t <= 'h205; t++) begin
            lookup(16'((t << (IDX + 1)) | (s << 1)));
            check("post_rst_miss", 32'(pred_hit), 32'd0);
         end
      end
      idle();
      check("post_rst_idle_valid", 32'(pred_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
